// File: rtl/geofence_driver_if.sv
// Bundle of the point push port, engine X/Y bus and result handshake of geofence_driver.
// master = the driver itself, slave = the pattern source / engine / result consumer side.
interface geofence_driver_if #(
    parameter int CNT_W = 16
);
    logic             pt_valid;
    logic             pt_ready;
    logic [9:0]       pt_x;
    logic [9:0]       pt_y;
    logic             fence_rst;
    logic [9:0]       X;
    logic [9:0]       Y;
    logic             fence_valid;
    logic             fence_inside;
    logic             res_valid;
    logic             res_ready;
    logic             res_inside;
    logic             res_timeout;
    logic             err_stray;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        input  pt_valid, pt_x, pt_y, fence_valid, fence_inside, res_ready,
        output pt_ready, fence_rst, X, Y, res_valid, res_inside, res_timeout,
               err_stray, frame_cnt
    );

    modport slave (
        output pt_valid, pt_x, pt_y, fence_valid, fence_inside, res_ready,
        input  pt_ready, fence_rst, X, Y, res_valid, res_inside, res_timeout,
               err_stray, frame_cnt
    );
endinterface

// File: rtl/geofence_driver.sv
// Transmit-side partner of the geofence engine: buffers a 7-point frame, resets the
// engine, serialises the points onto X/Y and hands back the inside/timeout result.
module geofence_driver #(
    parameter int TIMEOUT = 128,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    geofence_driver_if.master bus
);
    typedef enum logic [2:0] {
        S_LOAD,
        S_RST,
        S_SEND,
        S_WAIT,
        S_REPORT
    } state_t;

    localparam int TMR_W = $clog2(TIMEOUT);

    state_t           state_q;
    logic [2:0]       idx_q;
    logic [TMR_W-1:0] tmr_q;
    logic [19:0]      pt_buf_q [7];

    logic             pt_ready_q;
    logic             fence_rst_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic             res_valid_q;
    logic             res_inside_q;
    logic             res_timeout_q;
    logic             err_stray_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic             take;

    assign take = (state_q == S_LOAD) && bus.pt_valid && pt_ready_q;

    assign bus.pt_ready    = pt_ready_q;
    assign bus.fence_rst   = fence_rst_q;
    assign bus.X           = x_q;
    assign bus.Y           = y_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_inside  = res_inside_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.err_stray   = err_stray_q;
    assign bus.frame_cnt   = frame_cnt_q;

    // NOTE: the point buffer has no reset; the load index alone decides what is valid,
    // so a reset mid-frame discards the contents without clearing the storage.
    always_ff @(posedge clk) begin
        if (take) begin
            pt_buf_q[idx_q] <= {bus.pt_x, bus.pt_y};
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every branch
    // sees the values from before this edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            idx_q         <= '0;
            tmr_q         <= '0;
            pt_ready_q    <= 1'b0;
            fence_rst_q   <= 1'b1;
            x_q           <= '0;
            y_q           <= '0;
            res_valid_q   <= 1'b0;
            res_inside_q  <= 1'b0;
            res_timeout_q <= 1'b0;
            err_stray_q   <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            if (bus.fence_valid && (state_q != S_WAIT)) begin
                err_stray_q <= 1'b1;
            end

            case (state_q)
                S_LOAD: begin
                    pt_ready_q  <= 1'b1;
                    fence_rst_q <= 1'b0;
                    if (take) begin
                        if (idx_q == 3'd6) begin
                            // Object was captured first, so buf[0] is already valid here.
                            state_q     <= S_RST;
                            idx_q       <= '0;
                            pt_ready_q  <= 1'b0;
                            fence_rst_q <= 1'b1;
                            x_q         <= pt_buf_q[0][19:10];
                            y_q         <= pt_buf_q[0][9:0];
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end

                S_RST: begin
                    fence_rst_q <= 1'b0;
                    state_q     <= S_SEND;
                end

                S_SEND: begin
                    if (idx_q == 3'd6) begin
                        state_q <= S_WAIT;
                        tmr_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                        x_q   <= pt_buf_q[idx_q + 3'd1][19:10];
                        y_q   <= pt_buf_q[idx_q + 3'd1][9:0];
                    end
                end

                S_WAIT: begin
                    if (bus.fence_valid) begin
                        res_valid_q   <= 1'b1;
                        res_inside_q  <= bus.fence_inside;
                        res_timeout_q <= 1'b0;
                        state_q       <= S_REPORT;
                    end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                        res_valid_q   <= 1'b1;
                        res_inside_q  <= 1'b0;
                        res_timeout_q <= 1'b1;
                        state_q       <= S_REPORT;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_REPORT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        pt_ready_q  <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= S_LOAD;
                    end
                end

                default: state_q <= S_LOAD;
            endcase
        end
    end
endmodule
